seq_mul_vr: RTL and testbench

Parametrised sequential shift-add multiplier with valid/ready handshakes on both the input (src) and output (dest) sides. It is the successor to the fixed 16-bit signed sequential multiplier. It generalises operand width and adds a per-transaction signed/unsigned mode. It also supports back-to-back transactions and holds results stable under backpressure. It sits between a producer issuing operand pairs and a consumer that may stall.

---
 rtl/seq_mul_pkg.sv | 15 +
 rtl/seq_mul_dp.sv | 62 ++++++
 rtl/seq_mul_vr.sv | 80 ++++++++
 tb/tb_seq_mul_vr.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter that walks multiplier bits 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: operand registers, accumulator, iteration counter and
// the per-iteration add/subtract step.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               last
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

  // mcand_q holds the extended multiplicand already shifted left by the
  // current iteration index; mplier_q shifts right so bit 0 is always bit i.
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic             sgn_q;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    last    = (cnt_q == LAST_IT);
    acc_nxt = acc_q;
    if (mplier_q[0]) begin
      // The top multiplier bit carries negative weight in two's complement.
      if (sgn_q && last) acc_nxt = acc_q - mcand_q;
      else               acc_nxt = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      sgn_q    <= sgn;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_mul_vr.sv
// Sequential signed/unsigned multiplier with valid/ready on both sides;
// owns the FSM, handshakes and the registered product.
module seq_mul_vr
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_val,
  output logic               src_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               dest_val,
  input  logic               dest_ready,
  output logic [2*WIDTH-1:0] product
);

  // Handshake: a transfer happens on any rising edge where val && ready are
  // both high; a producer holds val and data until that edge, and dest_val
  // and product stay frozen until the consumer's ready edge.
  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] acc_nxt;

  assign accept = src_val && src_ready;
  assign step   = (state_q == CALC);

  always_comb begin
    src_ready = 1'b0;
    case (state_q)
      IDLE:    src_ready = 1'b1;
      DONE:    src_ready = dest_ready;
      default: src_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (dest_ready) state_d = src_val ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dest_val <= 1'b0;
      product  <= '0;
    end else begin
      state_q <= state_d;
      if (step && last) begin
        product  <= acc_nxt;
        dest_val <= 1'b1;
      end else if (state_q == DONE && dest_ready) begin
        dest_val <= 1'b0;
      end
    end
  end

  seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (step),
    .a       (multiplicand),
    .b       (multiplier),
    .sgn     (is_signed),
    .acc_nxt (acc_nxt),
    .last    (last)
  );

endmodule

// File: tb/tb_seq_mul_vr.sv
// Scoreboard bench for seq_mul_vr at WIDTH=16 and WIDTH=8 against an
// arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_mul_vr;

  localparam int W  = 16;
  localparam int W8 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_val, src_ready, sg, dest_val, dest_ready;
  logic [15:0] a, b;
  logic [31:0] product;
  logic        v8, r8, sg8, dv8, dr8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: stall, 2: random
  int n_consumed = 0;
  int n_b2b = 0;
  int n8 = 0;
  logic [31:0] last_prod;
  logic [15:0] last8;

  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  logic [15:0] exp8_q[$];
  int          acc8_q[$];

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  seq_mul_vr #(.WIDTH(W)) dut16 (
    .clk(clk), .rst(rst), .src_val(src_val), .src_ready(src_ready),
    .multiplicand(a), .multiplier(b), .is_signed(sg),
    .dest_val(dest_val), .dest_ready(dest_ready), .product(product)
  );

  seq_mul_vr #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .src_val(v8), .src_ready(r8),
    .multiplicand(a8), .multiplier(b8), .is_signed(sg8),
    .dest_val(dv8), .dest_ready(dr8), .product(p8)
  );

  // reference model: exact integer product, truncated to 2*WIDTH bits
  function automatic logic [31:0] ref16(input logic [15:0] x, y, input logic s);
    logic signed [63:0] xe, ye, p;
    xe = s ? 64'($signed(x)) : 64'(x);
    ye = s ? 64'($signed(y)) : 64'(y);
    p  = xe * ye;
    return p[31:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, y, input logic s);
    logic signed [63:0] xe, ye, p;
    xe = s ? 64'($signed(x)) : 64'(x);
    ye = s ? 64'($signed(y)) : 64'(y);
    p  = xe * ye;
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard, WIDTH=16
  logic        prev_hold = 1'b0;
  logic        prev_dv = 1'b0;
  logic [31:0] prev_prod = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      prev_hold = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_dest_val", 64'(dest_val), 64'd1);
        check("hold_product", 64'(product), 64'(prev_prod));
      end
      if (dest_val && !prev_dv) begin
        if (acc_cyc_q.size() == 0) check("unexpected_dest_val", 64'(dest_val), 64'd0);
        else check("latency16", 64'(cyc - acc_cyc_q.pop_front()), 64'(W));
      end
      if (dest_val && !dest_ready) check("src_ready_stall", 64'(src_ready), 64'd0);
      if (dest_val && dest_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'(dest_val), 64'd0);
        else check("product16", 64'(product), 64'(exp_q.pop_front()));
        last_prod = product;
        n_consumed++;
      end
      if (src_val && src_ready) begin
        exp_q.push_back(ref16(a, b, sg));
        acc_cyc_q.push_back(cyc + 1);
        if (dest_val && dest_ready) n_b2b++;
      end
      prev_hold = dest_val && !dest_ready;
      prev_prod = product;
      prev_dv   = dest_val;
    end
  end

  // monitor / scoreboard, WIDTH=8
  logic pdv8 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
      acc8_q.delete();
      pdv8 = 1'b0;
    end else begin
      if (dv8 && !pdv8) begin
        if (acc8_q.size() == 0) check("unexpected_dv8", 64'(dv8), 64'd0);
        else check("latency8", 64'(cyc - acc8_q.pop_front()), 64'(W8));
      end
      if (dv8 && dr8) begin
        if (exp8_q.size() == 0) check("unexpected_result8", 64'(dv8), 64'd0);
        else check("product8", 64'(p8), 64'(exp8_q.pop_front()));
        last8 = p8;
        n8++;
      end
      if (v8 && r8) begin
        exp8_q.push_back(ref8(a8, b8, sg8));
        acc8_q.push_back(cyc + 1);
      end
      pdv8 = dv8;
    end
  end

  // consumer ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dest_ready = 1'b1;
      1:       dest_ready = 1'b0;
      default: dest_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the accept edge
  task automatic send16(input logic [15:0] ai, input logic [15:0] bi, input logic si);
    int t = 0;
    src_val = 1'b1; a = ai; b = bi; sg = si;
    forever begin
      @(negedge clk);
      if (src_ready) break;
      t++;
      if (t > 200) begin
        check("accept_timeout16", 64'(src_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    src_val = 1'b0; a = 16'($urandom); b = 16'($urandom); sg = 1'($urandom);
  endtask

  task automatic send8(input logic [7:0] ai, input logic [7:0] bi, input logic si);
    int t = 0;
    v8 = 1'b1; a8 = ai; b8 = bi; sg8 = si;
    forever begin
      @(negedge clk);
      if (r8) break;
      t++;
      if (t > 200) begin
        check("accept_timeout8", 64'(r8), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain16();
    int t = 0;
    while ((exp_q.size() != 0 || dest_val) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) check("drain_timeout16", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drain8();
    int t = 0;
    while ((exp8_q.size() != 0 || dv8) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("drain_timeout8", 64'(exp8_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dest_val"}, 64'(dest_val), 64'd0);
    check({tag, "_product"}, 64'(product), 64'd0);
    check({tag, "_src_ready"}, 64'(src_ready), 64'd1);
  endtask

  logic [15:0] dir_a[5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000};
  logic [15:0] dir_b[5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234};
  logic        dir_s[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] dir_e[5] = '{32'hFFFE0001, 32'h00000001, 32'h40000000, 32'hC0008000, 32'h0};

  initial begin
    int b0, nc0, t;
    logic [15:0] ra, rb;
    rst = 1'b1; src_val = 1'b0; a = '0; b = '0; sg = 1'b0; dest_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; sg8 = 1'b0; dr8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    check("por_dv8", 64'(dv8), 64'd0);
    check("por_r8", 64'(r8), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send16(dir_a[i], dir_b[i], dir_s[i]);
      drain16();
      check($sformatf("directed%0d", i), 64'(last_prod), 64'(dir_e[i]));
    end

    // backpressure: result held while a new request waits
    ready_mode = 1;
    dest_ready = 1'b0;
    send16(16'd3, 16'd4, 1'b0);
    t = 0;
    while (!dest_val && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    nc0 = n_consumed;
    b0  = n_b2b;
    src_val = 1'b1; a = 16'd9; b = 16'd11; sg = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_dest_val", 64'(dest_val), 64'd1);
    check("bp_product", 64'(product), 64'd12);
    check("bp_not_consumed", 64'(n_consumed), 64'(nc0));
    ready_mode = 0;
    dest_ready = 1'b1;
    send16(16'd9, 16'd11, 1'b0);
    drain16();
    check("bp_same_edge_accept", 64'(n_b2b - b0), 64'd1);
    check("bp_second", 64'(last_prod), 64'd99);

    // back-to-back with src_val held
    b0 = n_b2b;
    send16(16'd3, 16'd5, 1'b0);
    send16(16'd7, 16'hFFFE, 1'b1);
    drain16();
    check("b2b_same_edge", 64'(n_b2b - b0), 64'd1);
    check("b2b_second", 64'(last_prod), 64'hFFFFFFF2);

    // reset mid-stream for 3 cycles
    send16(16'd1234, 16'd77, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset("midrst");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send16(16'd21, 16'd2, 1'b1);
    drain16();
    check("after_reset", 64'(last_prod), 64'd42);

    // abort during iteration 7 of 100*200
    nc0 = n_consumed;
    send16(16'd100, 16'd200, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_dest_val", 64'(dest_val), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_result", 64'(n_consumed), 64'(nc0));
    check("abort_idle_ready", 64'(src_ready), 64'd1);

    // randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      send16(ra, rb, 1'($urandom));
    end
    drain16();
    ready_mode = 0;

    // WIDTH=8 instance
    send8(8'h80, 8'h80, 1'b1);
    drain8();
    check("w8_signed_minmin", 64'(last8), 64'h4000);
    send8(8'hFF, 8'hFF, 1'b0);
    drain8();
    check("w8_unsigned_max", 64'(last8), 64'hFE01);
    for (int i = 0; i < 20; i++) send8(8'($urandom), 8'($urandom), 1'($urandom));
    drain8();
    check("w8_count", 64'(n8), 64'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
